// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a per-entry busy scoreboard and registered Full flag.
// Define RF_BYPASS_EN for write-first forwarding; the default build is read-first.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       RdEn,
  input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
  output logic [NUM_RD*DATA_W-1:0]   RdData,
  output logic [NUM_RD-1:0]          RdBusy,
  input  logic                       Write,
  input  logic [ADDR_W-1:0]          WR,
  input  logic [DATA_W-1:0]          WD,
  input  logic                       Rsv,
  input  logic [ADDR_W-1:0]          RsvAddr,
  output logic                       Full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic ZR = (ZERO_REG != 0);
  // Entry 0 is excluded from the Full test when it is the hardwired zero register.
  localparam logic [DEPTH-1:0] RSV_MASK = ZR ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              r_full;
  logic              w_full_nxt;
  logic              w_wr_ok;
  logic              w_rsv_ok;

  assign w_wr_ok  = Write && !(ZR && (WR == '0));
  assign w_rsv_ok = Rsv && !(ZR && (RsvAddr == '0));

  // Reservation is applied after the writeback clear so it wins on a same-address collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[WR]      = 1'b0;
    if (w_rsv_ok) w_busy_nxt[RsvAddr] = 1'b1;
  end

  assign w_full_nxt = &(w_busy_nxt | ~RSV_MASK);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_busy <= '0;
      r_full <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_full <= w_full_nxt;
    end
  end

  assign Full = r_full;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[WR] <= WD;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_rd_data_p1;

    assign w_addr = RdAddr[k*ADDR_W +: ADDR_W];
    assign w_zero = ZR && (w_addr == '0);

`ifdef RF_BYPASS_EN
    // A matching writeback is forwarded and hides the busy bit unless it is re-reserved this cycle.
    assign w_fwd     = w_wr_ok && (WR == w_addr);
    assign RdBusy[k] = r_busy[w_addr] && !w_zero &&
                       !(w_fwd && !(w_rsv_ok && (RsvAddr == w_addr)));
`else
    assign w_fwd     = 1'b0;
    assign RdBusy[k] = r_busy[w_addr] && !w_zero;
`endif

    assign w_rdata = w_zero ? '0 : (w_fwd ? WD : r_rf[w_addr]);

    // Stage p0 -> p1: one cycle of read latency, held while RdEn is low.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)     r_rd_data_p1 <= '0;
      else if (RdEn) r_rd_data_p1 <= w_rdata;
    end

    assign RdData[k*DATA_W +: DATA_W] = r_rd_data_p1;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NE = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              RdEn = 1'b0;
  logic [NR*AW-1:0]  RdAddr = '0;
  logic [NR*DW-1:0]  RdData;
  logic [NR-1:0]     RdBusy;
  logic              Write = 1'b0;
  logic [AW-1:0]     WR = '0;
  logic [DW-1:0]     WD = '0;
  logic              Rsv = 1'b0;
  logic [AW-1:0]     RsvAddr = '0;
  logic              Full;

  logic       s_rden = 1'b0;
  logic [1:0] s_raddr = '0;
  logic [7:0] s_rdata;
  logic [0:0] s_busy;
  logic       s_wr = 1'b0;
  logic [1:0] s_wa = '0;
  logic [7:0] s_wd = '0;
  logic       s_rsv = 1'b0;
  logic [1:0] s_ra = '0;
  logic       s_full;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .Clk(Clk), .Reset(Reset), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
    .RdBusy(RdBusy), .Write(Write), .WR(WR), .WD(WD), .Rsv(Rsv),
    .RsvAddr(RsvAddr), .Full(Full));

  reg_file_mp #(.DATA_W(8), .ADDR_W(2), .NUM_RD(1), .ZERO_REG(1)) dut_s (
    .Clk(Clk), .Reset(Reset), .RdEn(s_rden), .RdAddr(s_raddr), .RdData(s_rdata),
    .RdBusy(s_busy), .Write(s_wr), .WR(s_wa), .WD(s_wd), .Rsv(s_rsv),
    .RsvAddr(s_ra), .Full(s_full));

  // Reference model state
  logic [DW-1:0] m_rf [NE];
  bit            m_busy [NE];
  logic [DW-1:0] m_rd [NR];
  bit            m_full;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] port_addr(input int k);
    return RdAddr[k*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    for (int k = 0; k < NR; k++) m_rd[k] = '0;
    m_full = 1'b0;
  endtask

  task automatic model_step();
    int n;
    logic [AW-1:0] a;
    if (RdEn) begin
      for (int k = 0; k < NR; k++) begin
        a = port_addr(k);
        if (a == 0)                             m_rd[k] = '0;
        else if (BYP && Write && WR == a)       m_rd[k] = WD;
        else                                    m_rd[k] = m_rf[a];
      end
    end
    if (Write && WR != 0) begin
      m_rf[WR] = WD;
      m_busy[WR] = 1'b0;
    end
    if (Rsv && RsvAddr != 0) m_busy[RsvAddr] = 1'b1;
    n = 0;
    for (int i = 1; i < NE; i++) n += int'(m_busy[i]);
    m_full = (n == NE - 1);
  endtask

  function automatic bit exp_busy(input int k);
    logic [AW-1:0] a;
    a = port_addr(k);
    if (a == 0) return 1'b0;
    if (BYP && Write && WR == a && !(Rsv && RsvAddr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  initial forever begin
    @(posedge Clk or posedge Reset);
    if (Reset) model_reset();
    else       model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge Clk);
    #3;
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rd_data%0d", k), RdData[k*DW +: DW], m_rd[k]);
        chk($sformatf("rd_busy%0d", k), RdBusy[k], exp_busy(k));
      end
      chk("full", Full, m_full);
    end
  end

  task automatic cyc(input logic rden, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic rsv, input logic [AW-1:0] ra);
    @(negedge Clk);
    #1;
    RdEn = rden; RdAddr = {a1, a0};
    Write = wr; WR = wa; WD = wd;
    Rsv = rsv; RsvAddr = ra;
    @(posedge Clk);
    #1;
  endtask

  task automatic scyc(input logic wr, input logic [1:0] wa, input logic rsv, input logic [1:0] ra);
    @(negedge Clk);
    #1;
    s_wr = wr; s_wa = wa; s_wd = 8'h5A; s_rsv = rsv; s_ra = ra;
    s_rden = 1'b1; s_raddr = ra;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NE - 1));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    chk_en = 1'b1;

    // Reset mid-stream
    cyc(0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 0);
    cyc(1, 5, 7, 0, 0, 0, 1, 7);
    chk("t1_rd5", RdData[DW-1:0], 64'hA5A5A5A5);
    chk("t1_busy7", RdBusy[1], 64'd1);
    @(negedge Clk);
    #1 Reset = 1'b1; RdEn = 1'b0; Rsv = 1'b0;
    #1;
    chk("t1_rst_data", RdData, 64'd0);
    chk("t1_rst_busy", RdBusy, 64'd0);
    chk("t1_rst_full", Full, 64'd0);
    @(negedge Clk);
    #1 Reset = 1'b0;
    cyc(1, 5, 5, 0, 0, 0, 0, 0);
    chk("t1_rf5_cleared", RdData[DW-1:0], 64'd0);

    // Write then dual-port read of the same entry
    cyc(0, 0, 0, 1, 3, 32'h12345678, 0, 0);
    cyc(1, 3, 3, 0, 0, 0, 0, 0);
    chk("t2_port0", RdData[DW-1:0], 64'h12345678);
    chk("t2_port1", RdData[2*DW-1:DW], 64'h12345678);

    // Zero register ignores writes and reservations
    cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_zero_data", RdData, 64'd0);
    chk("t3_zero_busy", RdBusy, 64'd0);

    // Same-cycle write and read of entry 9
    cyc(0, 0, 0, 1, 9, 32'h1, 0, 0);
    cyc(1, 9, 9, 1, 9, 32'hCAFE, 0, 0);
    chk("t4_same_cycle", RdData[DW-1:0], BYP ? 64'hCAFE : 64'h1);
    cyc(1, 9, 9, 0, 0, 0, 0, 0);
    chk("t4_next_cycle", RdData[DW-1:0], 64'hCAFE);

    // Reservation versus writeback on entry 4
    cyc(0, 4, 4, 0, 0, 0, 1, 4);
    chk("t5_rsv", RdBusy, 64'd3);
    cyc(0, 4, 4, 1, 4, 32'h44, 1, 4);
    chk("t5_rsv_wins", RdBusy, 64'd3);
    cyc(0, 4, 4, 1, 4, 32'h45, 0, 0);
    chk("t5_wb_clears", RdBusy, 64'd0);

    // Fill every reservable entry of the main instance
    for (int i = 1; i < NE; i++) cyc(0, 0, 0, 0, 0, 0, 1, AW'(i));
    chk("full_set", Full, 64'd1);
    cyc(0, 0, 0, 1, 10, 32'h77, 0, 0);
    chk("full_clr", Full, 64'd0);
    cyc(0, 0, 0, 1, 0, 32'h1, 1, 10);
    chk("full_again", Full, 64'd1);

    // Small instance: three reservable entries
    scyc(0, 0, 1, 1);
    scyc(0, 0, 1, 2);
    chk("s_full_two", s_full, 64'd0);
    scyc(0, 0, 1, 3);
    chk("s_full_three", s_full, 64'd1);
    chk("s_busy3", s_busy, 64'd1);
    scyc(1, 2, 0, 0);
    chk("s_full_drop", s_full, 64'd0);
    scyc(0, 0, 1, 0);
    chk("s_rsv0_nop", s_full, 64'd0);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        #1 Reset = 1'b0;
      end
      cyc(1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
          1'($urandom_range(0, 1)), rnd_addr(), DW'($urandom()),
          ($urandom_range(0, 2) == 0), rnd_addr());
    end

    @(negedge Clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
